// File: rtl/mem_word_arbiter.sv
// Round-robin arbiter that shares a byte-wide data memory between two 32-bit word requesters
// (A = CPU, B = loader/DMA), sequencing each word as four little-endian byte accesses.
module mem_word_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       rd_data,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [DW-1:0]     drain_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic              gnt_b;      // port of the current/last grant: 1 = B
  logic              grant;
  logic              grant_b;
  logic              issue_rd;
  logic              cap_en;
  logic [1:0]        cap_idx;
  logic [31:0]       rd_buf, rd_buf_nxt;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant   = a_req | b_req;
    grant_b = b_req & (~a_req | ~gnt_b);
  end

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant) state_nxt = ISSUE;
      ISSUE: if (byte_cnt == 2'd3) state_nxt = (we_q || READ_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (drain_cnt == DW'(READ_LAT - 1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs decode straight from state, so an asynchronous reset drops mem_we at once.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (state)
      ISSUE: begin
        mem_we   = we_q;
        mem_addr = base_q + ADDR_W'(byte_cnt);
        mem_din  = wdata_q[8*byte_cnt +: 8];
      end
      DRAIN: mem_addr = base_q + ADDR_W'(3);
      default: ;
    endcase
  end

  assign a_ack    = (state == DONE) & ~gnt_b;
  assign b_ack    = (state == DONE) &  gnt_b;
  assign busy     = (state != IDLE);
  assign issue_rd = (state == ISSUE) & ~we_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      drain_cnt <= '0;
      we_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      gnt_b     <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant) begin
        we_q     <= grant_b ? b_we : a_we;
        base_q   <= (grant_b ? b_addr : a_addr) & ~ADDR_W'(3);
        wdata_q  <= grant_b ? b_wdata : a_wdata;
        gnt_b    <= grant_b;
        byte_cnt <= '0;
      end else if (state == ISSUE) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  // Each issued read byte travels down a READ_LAT-deep tag pipe and is captured when it emerges.
  generate
    if (READ_LAT == 0) begin : g_comb_read
      assign cap_en  = issue_rd;
      assign cap_idx = byte_cnt;
    end else begin : g_pipe_read
      logic [READ_LAT-1:0] pipe_v;
      logic [1:0]          pipe_i [READ_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_v <= '0;
          for (int k = 0; k < READ_LAT; k++) pipe_i[k] <= '0;
        end else begin
          pipe_v[0] <= issue_rd;
          pipe_i[0] <= byte_cnt;
          for (int k = 1; k < READ_LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_i[k] <= pipe_i[k-1];
          end
        end
      end

      assign cap_en  = pipe_v[READ_LAT-1];
      assign cap_idx = pipe_i[READ_LAT-1];
    end
  endgenerate

  always_comb begin
    rd_buf_nxt = rd_buf;
    if (cap_en) rd_buf_nxt[8*cap_idx +: 8] = mem_dout;
  end

  // rd_data only updates as a read enters DONE, so it holds the last completed read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_buf  <= '0;
      rd_data <= '0;
    end else begin
      rd_buf <= rd_buf_nxt;
      if (state_nxt == DONE && !we_q) rd_data <= rd_buf_nxt;
    end
  end

endmodule

// File: tb/tb_mem_word_arbiter.sv
// Self-checking bench for mem_word_arbiter: directed transactions push expected acks into a
// scoreboard; a negedge monitor pops and checks port, cycle and read data on every ack.
module tb_mem_word_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [31:0]       a_wdata = '0, b_wdata = '0;
  logic              a_ack, b_ack, busy, mem_we;
  logic [31:0]       rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout = '0;

  mem_word_arbiter #(.ADDR_W(ADDR_W), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rd_data(rd_data), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Byte memory with one cycle of read latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_din;
    mem_dout <= mem[mem_addr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          port_b;
    bit          we;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [31:0] last_rd = '0;

  always @(negedge clk) begin
    if (rst) begin
      last_rd = '0;
    end else if (a_ack || b_ack) begin
      check("both_acks", a_ack && b_ack, 0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        check("ack_port", b_ack, e.port_b);
        check("ack_cycle", cyc, e.due);
        if (!e.we) last_rd = e.data;
        check("rd_data", rd_data, last_rd);
      end
    end
  end

  task automatic run_txn(input bit port_b, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd);
    int          c;
    bit          got;
    logic [31:0] base;
    base = addr & 32'hFFFF_FFFC;
    @(posedge clk); #1;
    c = cyc;
    if (port_b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
    sb.push_back('{port_b, we, exp_rd, c + 5 + (we ? 0 : 1)});
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bus_we", mem_we, we);
      check("bus_addr", mem_addr, base + i);
      if (we) check("bus_din", mem_din, (wdata >> (8*i)) & 32'hFF);
    end
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      got = port_b ? b_ack : a_ack;
    end
    check("ack_seen", got, 1);
    @(posedge clk); #1;
    if (port_b) b_req = 1'b0; else a_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset with both requesters asking to write; they then stay high for four grants.
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'h0102_0304;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_wdata = 32'h0506_0708;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);

    @(posedge clk); #1;
    rst = 1'b0;
    c0 = cyc;
    sb.push_back('{1'b0, 1'b1, 32'h0, c0 + 5});
    sb.push_back('{1'b1, 1'b1, 32'h0, c0 + 11});
    sb.push_back('{1'b0, 1'b1, 32'h0, c0 + 17});
    sb.push_back('{1'b1, 1'b1, 32'h0, c0 + 23});
    @(negedge clk);
    check("rr_idle_busy", busy, 0);
    @(negedge clk);
    check("rr_first_busy", busy, 1);
    check("rr_first_we", mem_we, 1);
    check("rr_first_addr", mem_addr, 32'h30);
    check("rr_first_din", mem_din, 8'h04);
    repeat (23) @(posedge clk);
    #1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) @(posedge clk);
    check("rr_all_acked", sb.size(), 0);

    // A writes a word, reads it back; B reads it through a misaligned address.
    run_txn(1'b0, 1'b1, 32'h10, 32'hAABB_CCDD, 32'h0);
    check("mem_10", mem[8'h10], 8'hDD);
    check("mem_13", mem[8'h13], 8'hAA);
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hAABB_CCDD);
    run_txn(1'b1, 1'b0, 32'h13, 32'h0, 32'hAABB_CCDD);

    // Preload 0x20, then reset a second write after its first two bytes have been committed.
    run_txn(1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, 32'h0);
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #2;
    check("abort_we_before", mem_we, 1);
    check("abort_addr_before", mem_addr, 32'h22);
    rst = 1'b1;
    #1;
    check("abort_we_async", mem_we, 0);
    check("abort_busy", busy, 0);
    check("abort_a_ack", a_ack, 0);
    check("abort_mem_din", mem_din, 0);
    a_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(1'b0, 1'b0, 32'h20, 32'h0, 32'hA5A5_3344);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
